// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: sizing of the occupancy counter.
package elastic_pipe_pkg;

    // Counter must represent 0..DEPTH+1 so the skid build fits without resizing.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Handshake bundle for elastic_pipeline: upstream (valid_in/data_in/ready_out)
// and downstream (valid_out/data_out/ready_in) channels in one interface.
interface elastic_pipeline_if #(
    parameter int WIDTH = 8
);
    // A beat transfers on a clock edge where valid and ready are both 1; once
    // valid is raised, valid and data hold stable until that edge.
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out
    );
endinterface

// File: rtl/elastic_pipeline_skid_buffer.sv
// One-entry skid buffer: breaks the combinational ready path in front of the
// elastic stage chain; empty skid passes beats straight through.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_in
);
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;

    assign ready_out = rst_n_in & ~skid_valid_q;
    assign valid_out = skid_valid_q | valid_in;
    assign data_out  = skid_valid_q ? skid_data_q : data_in;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (flush_in) begin
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (ready_in) skid_valid_q <= 1'b0;
        end else if (valid_in && !ready_in) begin
            // Accepted while downstream is blocked: park it.
            skid_valid_q <= 1'b1;
            skid_data_q  <= data_in;
        end
    end
endmodule

// File: rtl/elastic_pipeline.sv
// Valid/ready register chain with bubble collapse, flush and occupancy count.
// Optional input skid buffer enabled by defining ELASTIC_PIPE_SKID_EN.
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          flush_in,
    elastic_pipeline_if.slave             bus,
    output logic [occ_width(DEPTH)-1:0]   occupancy_out
);
    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             chain;
    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;
    logic             in_xfer;
    logic             out_xfer;
    logic [OW-1:0]    occ_q;

    // A stage may load when it is empty or everything ahead of it moves.
    always_comb begin
        chain = bus.ready_in;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = ~vld_q[i] | chain;
            adv[i] = chain;
        end
    end

`ifdef ELASTIC_PIPE_SKID_EN
    skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .flush_in  (flush_in),
        .valid_in  (bus.valid_in),
        .data_in   (bus.data_in),
        .ready_out (bus.ready_out),
        .valid_out (s0_valid),
        .data_out  (s0_data),
        .ready_in  (adv[0])
    );
`else
    assign s0_valid      = bus.valid_in;
    assign s0_data       = bus.data_in;
    assign bus.ready_out = rst_n_in & adv[0];
`endif

    assign in_xfer       = bus.valid_in & bus.ready_out;
    assign out_xfer      = vld_q[DEPTH-1] & bus.ready_in;
    assign bus.valid_out = vld_q[DEPTH-1];
    assign bus.data_out  = dat_q[DEPTH-1];
    assign occupancy_out = occ_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (flush_in) begin
            // Data registers keep stale contents; only validity is dropped.
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            if (adv[0]) begin
                vld_q[0] <= s0_valid;
                dat_q[0] <= s0_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
            if (in_xfer && !out_xfer)      occ_q <= occ_q + OW'(1);
            else if (out_xfer && !in_xfer) occ_q <= occ_q - OW'(1);
        end
    end
endmodule
